// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the I-cache (read-only) and the D-cache.
// Accesses are serialised and held stable for MEM_LATENCY cycles, and each one ends with a per-side done pulse.
//   state  | meaning
//   IDLE   | arbitrate between the sampled requests
//   ACCESS | drive the memory port from the latched request
//   DONE   | pulse the owner's done; the memory port is quiet
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 5,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_grant_valid;
    logic                w_grant_side;
    logic                w_access;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_owner;
    logic                r_last_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    always_comb begin
        w_next_state  = r_state;
        w_grant_valid = 1'b0;
        w_grant_side  = OWN_I;
        case (r_state)
            ST_IDLE: begin
                if (i_req && d_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_side  = (r_last_grant == OWN_I) ? OWN_D : OWN_I;
                end else if (d_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_side  = OWN_D;
                end else if (i_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_side  = OWN_I;
                end
                if (w_grant_valid) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The grant snapshots the request so the memory port never follows live inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt        <= '0;
            r_owner      <= OWN_I;
            r_last_grant <= OWN_I;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner      <= w_grant_side;
                        r_last_grant <= w_grant_side;
                        r_addr       <= (w_grant_side == OWN_D) ? d_addr : i_addr;
                        r_we         <= (w_grant_side == OWN_D) && d_we;
                        r_wdata      <= (w_grant_side == OWN_D) ? d_wdata : '0;
                        r_cnt        <= CNT_LOAD;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == '0) begin
                        if (!r_we) begin
                            if (r_owner == OWN_D) begin
                                r_d_rdata <= mem_rdata;
                            end else begin
                                r_i_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_access  = (r_state == ST_ACCESS);
    assign mem_req   = w_access;
    assign mem_we    = w_access && r_we;
    assign mem_addr  = w_access ? r_addr : '0;
    assign mem_wdata = w_access ? r_wdata : '0;
    assign i_done    = (r_state == ST_DONE) && (r_owner == OWN_I);
    assign d_done    = (r_state == ST_DONE) && (r_owner == OWN_D);
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign busy      = (r_state != ST_IDLE);

endmodule
